// File: rtl/pipe_adder_pkg.sv
// Shared types and helpers for the pipelined ripple-carry adder.
package pipe_adder_pkg;

  // Control bits carried alongside each pipeline stage's data.
  typedef struct packed {
    logic valid;
    logic carry;
    logic msb_carry;
  } stage_t;

  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction

  // Operand width has to split into equal, non-empty chunks.
  function automatic bit geometry_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

  // One full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

endpackage

// File: rtl/pipe_adder_slice.sv
// Combinational CW-bit ripple of full-adder cells; one per pipeline stage.
module adder_slice
  import pipe_adder_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] sum,
  output logic          cout,
  output logic          cmsb
);

  logic [CW:0] c;

  // Ripple the carry through the chunk bit by bit.
  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < CW; i++) begin
      {c[i+1], sum[i]} = full_add(a[i], b[i], c[i]);
    end
  end

  assign cout = c[CW];
  assign cmsb = c[CW-1];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit ripple-carry adder, STAGES chunks, valid/ready on both sides.
// Optional macro PIPE_ADDER_SUB_EN adds a 'sub' input: a + ~b + 1, cin ignored.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PIPE_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = chunk_w(WIDTH, STAGES);

  if (!geometry_ok(WIDTH, STAGES)) begin : g_bad_geometry
    $error("pipe_adder: WIDTH must be a multiple of STAGES and STAGES in 1..WIDTH");
  end

  stage_t [STAGES-1:0]            st_q;
  logic   [STAGES-1:0][WIDTH-1:0] a_q, b_q, s_q;
  logic   [STAGES-1:0][WIDTH-1:0] a_src, b_src, s_src, s_nxt;
  logic   [STAGES-1:0]            c_src, v_src, co_c, cm_c;
  logic   [STAGES-1:0][CW-1:0]    sum_c;
  logic   [WIDTH-1:0]             b_eff;
  logic                           c_eff;
  logic                           advance;
  logic                           unused_skew;

  // Subtraction folds into the first stage as an inverted B with carry-in forced high.
`ifdef PIPE_ADDER_SUB_EN
  assign b_eff = sub ? ~b : b;
  assign c_eff = sub ? 1'b1 : cin;
`else
  assign b_eff = b;
  assign c_eff = cin;
`endif

  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;

  // Each stage sees either the ports (stage 0) or the previous stage's registers.
  always_comb begin
    a_src    = '0;
    b_src    = '0;
    s_src    = '0;
    c_src    = '0;
    v_src    = '0;
    a_src[0] = a;
    b_src[0] = b_eff;
    c_src[0] = c_eff;
    v_src[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_src[k] = a_q[k-1];
      b_src[k] = b_q[k-1];
      s_src[k] = s_q[k-1];
      c_src[k] = st_q[k-1].carry;
      v_src[k] = st_q[k-1].valid;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_slice #(.CW(CW)) u_slice (
      .a    (a_src[k][k*CW +: CW]),
      .b    (b_src[k][k*CW +: CW]),
      .cin  (c_src[k]),
      .sum  (sum_c[k]),
      .cout (co_c[k]),
      .cmsb (cm_c[k])
    );
  end

  // Merge each stage's fresh chunk into the partial sum it forwards.
  always_comb begin
    s_nxt = s_src;
    for (int k = 0; k < STAGES; k++) begin
      s_nxt[k][k*CW +: CW] = sum_c[k];
    end
  end

  // All stages advance together; a global stall freezes the whole pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      s_q  <= '0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        st_q[k].valid     <= v_src[k];
        st_q[k].carry     <= co_c[k];
        st_q[k].msb_carry <= cm_c[k];
        a_q[k]            <= a_src[k];
        b_q[k]            <= b_src[k];
        s_q[k]            <= s_nxt[k];
      end
    end
  end

  assign out_valid = st_q[STAGES-1].valid;
  assign sum       = s_q[STAGES-1];
  assign cout      = st_q[STAGES-1].carry;
  assign ovf       = st_q[STAGES-1].carry ^ st_q[STAGES-1].msb_carry;

  // Last-stage skew registers and intermediate msb carries have no consumer.
  assign unused_skew = ^{a_q[STAGES-1], b_q[STAGES-1], st_q};

endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder (WIDTH=16, STAGES=4).
module tb_pipe_adder;

  localparam int WIDTH  = 16;
  localparam int STAGES = 4;

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             o;
    int               exp_cyc;
    bit               lat;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
`ifdef PIPE_ADDER_SUB_EN
  logic             sub = 1'b0;
`endif

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   pushed = 0;
  int   popped = 0;
  int   flushed = 0;

  pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef PIPE_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: every output transfer is matched against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual sum=0x%0h required=no result", sum);
      end else begin
        e = sb.pop_front();
        popped++;
        chk("sum", 32'(sum), 32'(e.s));
        chk("cout", 32'(cout), 32'(e.c));
        chk("ovf", 32'(ovf), 32'(e.o));
        if (e.lat) chk("latency_cycle", 32'(cyc), 32'(e.exp_cyc));
      end
    end
  end

  // Present one operand set and hold it until the DUT accepts it.
  task automatic send(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic vc,
                      input logic [WIDTH-1:0] es, input logic ec, input logic eo, input bit lat);
    int   n;
    bit   ok;
    exp_t e;
    @(posedge clk);
    #1;
    a        = va;
    b        = vb;
    cin      = vc;
    in_valid = 1'b1;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else n++;
    end
    if (ok) begin
      e.s       = es;
      e.c       = ec;
      e.o       = eo;
      e.exp_cyc = cyc + STAGES;
      e.lat     = lat;
      sb.push_back(e);
      pushed++;
    end else begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=in_ready held 0 required=accepted");
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_sum", 32'(sum), 32'd0);
    chk("reset_cout", 32'(cout), 32'd0);
    chk("reset_ovf", 32'(ovf), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);

    // Directed vectors with out_ready held high; latency and throughput checked.
    send(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    send(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
    send(16'h1234, 16'h0000, 1'b1, 16'h1235, 1'b0, 1'b0, 1'b1);
    send(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
    send(16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    send(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b1);
    idle();
    wait_empty("drain_basic");

    send(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1);
    send(16'h0002, 16'h0002, 1'b0, 16'h0004, 1'b0, 1'b0, 1'b1);
    send(16'h0003, 16'h0003, 1'b0, 16'h0006, 1'b0, 1'b0, 1'b1);
    send(16'h0004, 16'h0004, 1'b0, 16'h0008, 1'b0, 1'b0, 1'b1);
    idle();
    wait_empty("drain_b2b");

    // Fill the pipe against a stalled sink, hold it, then drain.
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0);
    send(16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0, 1'b0);
    send(16'hFFFE, 16'h0001, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
    send(16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    idle();
    chk("stall_queue_depth", 32'(sb.size()), 32'd4);
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_sum_held", 32'(sum), 32'h3333);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_empty("drain_stall");

    // Reset with operations in flight.
    send(16'h0010, 16'h0020, 1'b0, 16'h0030, 1'b0, 1'b0, 1'b0);
    send(16'h0100, 16'h0200, 1'b0, 16'h0300, 1'b0, 1'b0, 1'b0);
    send(16'h1000, 16'h2000, 1'b0, 16'h3000, 1'b0, 1'b0, 1'b0);
    idle();
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("pre_reset_out_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_out_valid", 32'(out_valid), 32'd0);
    chk("async_reset_sum", 32'(sum), 32'd0);
    flushed += sb.size();
    sb.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("post_reset_out_valid", 32'(out_valid), 32'd0);
    end
    send(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b1);
    idle();
    wait_empty("drain_post_reset");

`ifdef PIPE_ADDER_SUB_EN
    @(posedge clk);
    #1 sub = 1'b1;
    send(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1);
    send(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b1);
    idle();
    sub = 1'b0;
    send(16'h0005, 16'h0007, 1'b0, 16'h000C, 1'b0, 1'b0, 1'b1);
    idle();
    wait_empty("drain_sub");
`endif

    repeat (3) @(negedge clk);
    chk("results_accounted", 32'(popped + flushed), 32'(pushed));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=still running required=finished");
    $fatal(1, "timeout");
  end

endmodule
